// File: rtl/blake2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blake2_pkg : shared BLAKE2s constants and feeder state encoding. Rev 1.0 |
// +--------------------------------------------------------------------------+
package blake2_pkg;

   localparam int BLAKE2S_BB     = 64;
   localparam int BLAKE2S_NN_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WAIT = 2'd2,
      ST_SEND = 2'd3
   } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/blake2_blk_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blake2_blk_buf : one-block byte buffer, zero-fills reads past fill count |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module blake2_blk_buf
#(
   parameter int BB    = 64,
   parameter int IDX_W = $clog2(BB),
   parameter int CNT_W = IDX_W + 1
)
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [CNT_W-1:0] cnt,
   output logic [7:0]       rd_data
);

   // Contents are never reset: only entries below the fill count are ever read out.
   logic [7:0] mem [BB];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = ({1'b0, rd_idx} < cnt) ? mem[rd_idx] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/blake2s_msg_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blake2s_msg_feeder : frames a byte stream into padded 64-byte blocks for |
// | the BLAKE2s core (unkeyed).  Rev 1.0                                     |
// +--------------------------------------------------------------------------+
module blake2s_msg_feeder
   import blake2_pkg::*;
#(
   parameter int BB   = BLAKE2S_BB,
   parameter int LL_W = 64,
   parameter int NN   = BLAKE2S_NN_MAX
)
(
   input  logic            clk,
   input  logic            nreset,
   input  logic            start_i,
   input  logic [5:0]      nn_i,
   input  logic            s_valid_i,
   input  logic [7:0]      s_data_i,
   input  logic            s_last_i,
   input  logic            s_empty_i,
   output logic            s_ready_o,
   input  logic            core_ready_i,
   output logic            block_first_o,
   output logic            block_last_o,
   output logic            data_v_o,
   output logic [5:0]      data_idx_o,
   output logic [7:0]      data_o,
   output logic [LL_W-1:0] ll_o,
   output logic [5:0]      kk_o,
   output logic [5:0]      nn_o,
   output logic            busy_o
);

   localparam int IDX_W = $clog2(BB);
   localparam int CNT_W = IDX_W + 1;

   feeder_state_e    state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [LL_W-1:0]  ll;
   logic             first_flag;
   logic             last_flag;
   logic [5:0]       nn;

   logic             accept;
   logic             empty_beat;
   logic             wr_en;
   logic             close_blk;
   logic             in_send;
   logic [7:0]       rd_data;

   assign accept     = (state == ST_FILL) && s_valid_i;
   assign empty_beat = s_last_i && s_empty_i;
   assign wr_en      = accept && !empty_beat;
   // cnt==BB-1 here means the beat being written is the block's final byte.
   assign close_blk  = accept && (s_last_i || (cnt == CNT_W'(BB - 1)));
   assign in_send    = (state == ST_SEND);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         idx        <= '0;
         ll         <= '0;
         first_flag <= 1'b0;
         last_flag  <= 1'b0;
         nn         <= 6'(NN);
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start_i) begin
                  nn         <= (nn_i == 6'd0) ? 6'(NN) : nn_i;
                  ll         <= '0;
                  cnt        <= '0;
                  first_flag <= 1'b1;
                  last_flag  <= 1'b0;
                  state      <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (wr_en) begin
                  cnt <= cnt + CNT_W'(1);
                  if (~&ll) begin
                     ll <= ll + LL_W'(1);
                  end
               end
               if (close_blk) begin
                  last_flag <= s_last_i;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (core_ready_i) begin
                  idx   <= '0;
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               idx <= idx + IDX_W'(1);
               if (idx == IDX_W'(BB - 1)) begin
                  first_flag <= 1'b0;
                  cnt        <= '0;
                  state      <= last_flag ? ST_IDLE : ST_FILL;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   blake2_blk_buf #(
      .BB    (BB),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (cnt[IDX_W-1:0]),
      .wr_data (s_data_i),
      .rd_idx  (idx),
      .cnt     (cnt),
      .rd_data (rd_data)
   );

   assign s_ready_o     = (state == ST_FILL);
   assign busy_o        = (state != ST_IDLE);
   assign data_v_o      = in_send;
   assign data_idx_o    = in_send ? 6'(idx) : 6'd0;
   assign data_o        = in_send ? rd_data : 8'h00;
   assign block_first_o = in_send && first_flag;
   assign block_last_o  = in_send && last_flag;
   assign ll_o          = ll;
   assign kk_o          = 6'd0;
   assign nn_o          = nn;

endmodule
`default_nettype wire
